// File: rtl/qam16_hard_slicer.sv
// Hard-decision 16-QAM slicer: slices signed I/Q to Gray 2-bit levels and packs two nibbles per FIFO byte.
// Optional outlier counter output err_count enabled by `define QAM16_SLICER_ERRCNT_EN.

module qam16_axis_slicer #(
  parameter int W      = 8,
  parameter int THRESH = 32
) (
  input  logic signed [W-1:0] x,
  output logic        [1:0]   bits
);
  localparam logic signed [W-1:0] POS_T = W'(THRESH);
  localparam logic signed [W-1:0] NEG_T = W'(-THRESH);

  // Gray order across the four levels: 00,01,11,10 from most negative upward
  always_comb begin
    if (x < NEG_T)       bits = 2'b00;
    else if (x[W-1])     bits = 2'b01;
    else if (x < POS_T)  bits = 2'b11;
    else                 bits = 2'b10;
  end
endmodule

module qam16_hard_slicer #(
  parameter int W      = 8,
  parameter int THRESH = 32
) (
  input  logic         sclk,
  input  logic         reset,
  input  logic         enable,
  input  logic         sym_valid,
  input  logic [W-1:0] i_in,
  input  logic [W-1:0] q_in,
  input  logic         wfull,
  output logic [7:0]   wr_data,
  output logic         wr_req,
  output logic         busy,
  output logic         overflow
`ifdef QAM16_SLICER_ERRCNT_EN
  , output logic [15:0] err_count
`endif
);
  typedef enum logic [1:0] {IDLE, NIB0, NIB1} state_e;

  state_e             state_q, state_d;
  logic               s1_vld_q, s1_vld_d;
  logic [1:0][W-1:0]  s1_iq_q, s1_iq_d;   // [1]=I, [0]=Q
  logic [1:0][1:0]    nib;                // {I bits, Q bits}
  logic [3:0]         hi_nib_q, hi_nib_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               wr_req_q, wr_req_d;
  logic               overflow_q, overflow_d;
  logic               s2_take;

  for (genvar a = 0; a < 2; a++) begin : g_axis
    qam16_axis_slicer #(.W(W), .THRESH(THRESH)) u_slc (
      .x    (s1_iq_q[a]),
      .bits (nib[a])
    );
  end

  assign s2_take = enable & s1_vld_q;

  always_ff @(posedge sclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    state_d = NIB0;
        NIB0:    if (s1_vld_q) state_d = NIB1;
        NIB1:    if (s1_vld_q) state_d = NIB0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    s1_vld_d   = enable & sym_valid;
    s1_iq_d    = enable ? {i_in, q_in} : s1_iq_q;
    hi_nib_d   = hi_nib_q;
    wr_data_d  = wr_data_q;
    wr_req_d   = 1'b0;
    overflow_d = overflow_q;
    if (s2_take) begin
      if (state_q == NIB0) hi_nib_d = nib;
      else if (state_q == NIB1) begin
        // Source cannot be stalled: a full FIFO drops the byte and flags it
        if (wfull) overflow_d = 1'b1;
        else begin
          wr_req_d  = 1'b1;
          wr_data_d = {hi_nib_q, nib};
        end
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_iq_q    <= '0;
      hi_nib_q   <= 4'h0;
      wr_data_q  <= 8'h00;
      wr_req_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_iq_q    <= s1_iq_d;
      hi_nib_q   <= hi_nib_d;
      wr_data_q  <= wr_data_d;
      wr_req_q   <= wr_req_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_data  = wr_data_q;
  assign wr_req   = wr_req_q;
  assign busy     = (state_q == NIB1);
  assign overflow = overflow_q;

`ifdef QAM16_SLICER_ERRCNT_EN
  localparam logic signed [W+1:0] LIM_P = (W+2)'(2 * THRESH);
  localparam logic signed [W+1:0] LIM_N = (W+2)'(-2 * THRESH);

  logic [1:0]  outl;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Two guard bits so 2*THRESH never wraps at W bits
  for (genvar a = 0; a < 2; a++) begin : g_outl
    logic signed [W+1:0] xe;
    assign xe      = {{2{s1_iq_q[a][W-1]}}, s1_iq_q[a]};
    assign outl[a] = (xe >= LIM_P) || (xe <= LIM_N);
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_take && (|outl) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge sclk) begin
    if (reset) err_cnt_q <= 16'h0000;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_qam16_hard_slicer.sv
// Self-checking bench for qam16_hard_slicer: directed plan steps then randomized traffic vs. a level/pair model.
module tb_qam16_hard_slicer;
  localparam int W = 8;
  localparam int THRESH = 32;

  logic              sclk = 1'b0;
  logic              reset, enable, sym_valid, wfull;
  logic signed [7:0] i_in, q_in;
  logic [7:0]        wr_data;
  logic              wr_req, busy, overflow;
`ifdef QAM16_SLICER_ERRCNT_EN
  logic [15:0]       err_count;
`endif

  qam16_hard_slicer #(.W(W), .THRESH(THRESH)) dut (
    .sclk      (sclk),
    .reset     (reset),
    .enable    (enable),
    .sym_valid (sym_valid),
    .i_in      (i_in),
    .q_in      (q_in),
    .wfull     (wfull),
    .wr_data   (wr_data),
    .wr_req    (wr_req),
    .busy      (busy),
    .overflow  (overflow)
`ifdef QAM16_SLICER_ERRCNT_EN
    , .err_count (err_count)
`endif
  );

  always #5 sclk = ~sclk;

  int tests = 0;
  int fails = 0;

  // Reference state: pending first nibble, last byte, sticky flag, outlier count
  int         p_vld, p_i, p_q;
  int         m_have, m_hi, m_req, m_data, m_ovf, m_cnt;
  int         gray_tab[4] = '{0, 1, 3, 2};
  logic signed [7:0] bnd[12] = '{8'sd0, -8'sd1, 8'sd31, 8'sd32, -8'sd32, -8'sd33,
                                 8'sd63, 8'sd64, -8'sd64, -8'sd65, 8'sd127, -8'sd128};

  function automatic int gray_of(input int x);
    int lvl;
    if (x < -THRESH)     lvl = 0;
    else if (x < 0)      lvl = 1;
    else if (x < THRESH) lvl = 2;
    else                 lvl = 3;
    return gray_tab[lvl];
  endfunction

  function automatic int is_outlier(input int x);
    return ((x >= 2*THRESH) || (-x >= 2*THRESH)) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    p_vld = 0; p_i = 0; p_q = 0;
    m_have = 0; m_hi = 0; m_req = 0; m_data = 0; m_ovf = 0; m_cnt = 0;
  endtask

  // One clock: apply inputs, take the edge, advance the model, compare
  task automatic cyc(input logic rst, input logic en, input logic v,
                     input logic signed [7:0] i, input logic signed [7:0] q, input logic wf);
    int nibv;
    reset = rst; enable = en; sym_valid = v; i_in = i; q_in = q; wfull = wf;
    @(posedge sclk);
    #1;
    if (rst) model_reset();
    else begin
      m_req = 0;
      if (!en) m_have = 0;
      else if (p_vld != 0) begin
        nibv = gray_of(p_i) * 4 + gray_of(p_q);
        if ((is_outlier(p_i) + is_outlier(p_q)) != 0 && m_cnt < 65535) m_cnt++;
        if (m_have == 0) begin
          m_hi = nibv; m_have = 1;
        end else begin
          m_have = 0;
          if (wf) m_ovf = 1;
          else begin
            m_req = 1; m_data = m_hi * 16 + nibv;
          end
        end
      end
      p_vld = (en && v) ? 1 : 0;
      if (en) begin p_i = int'(i); p_q = int'(q); end
    end
    chk("wr_req",   16'(wr_req),   16'(m_req));
    chk("wr_data",  16'(wr_data),  16'(m_data));
    chk("busy",     16'(busy),     16'(m_have));
    chk("overflow", 16'(overflow), 16'(m_ovf));
`ifdef QAM16_SLICER_ERRCNT_EN
    chk("err_count", err_count, 16'(m_cnt));
`endif
  endtask

  function automatic logic signed [7:0] pick();
    int sel;
    sel = $urandom_range(0, 15);
    if (sel < 12) return bnd[sel];
    return 8'($urandom);
  endfunction

  initial begin
    int req_seen;
    model_reset();
    reset = 1; enable = 0; sym_valid = 0; i_in = 0; q_in = 0; wfull = 0;

    repeat (3) cyc(1, 1, 0, 0, 0, 0);
    chk("rst_wr_data", 16'(wr_data), 16'h00);
    chk("rst_busy", 16'(busy), 16'h0);

    // Basic pair -> 0x93, two edges after the second sample
    cyc(0, 1, 1, 48, -10, 0);
    cyc(0, 1, 1, -48, 10, 0);
    chk("lat_early", 16'(wr_req), 16'h0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("byte_93", 16'(wr_data), 16'h93);
    chk("req_93", 16'(wr_req), 16'h1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("req_once", 16'(wr_req), 16'h0);

    // Threshold boundaries on I
    cyc(0, 1, 1, 0, 0, 0);   cyc(0, 1, 1, 32, 0, 0);  cyc(0, 1, 0, 0, 0, 0);
    chk("byte_FB", 16'(wr_data), 16'hFB);
    cyc(0, 1, 1, -1, 0, 0);  cyc(0, 1, 1, -32, 0, 0); cyc(0, 1, 0, 0, 0, 0);
    chk("byte_77", 16'(wr_data), 16'h77);
    cyc(0, 1, 1, -33, 0, 0); cyc(0, 1, 1, 31, 0, 0);  cyc(0, 1, 0, 0, 0, 0);
    chk("byte_3F", 16'(wr_data), 16'h3F);

    // Full FIFO in the completion cycle drops the byte
    cyc(0, 1, 1, 48, 48, 0); cyc(0, 1, 1, 48, 48, 0); cyc(0, 1, 0, 0, 0, 1);
    chk("ovf_set", 16'(overflow), 16'h1);
    chk("ovf_noreq", 16'(wr_req), 16'h0);
    cyc(0, 1, 1, 48, 48, 0); cyc(0, 1, 1, 48, 48, 0); cyc(0, 1, 0, 0, 0, 0);
    chk("byte_AA", 16'(wr_data), 16'hAA);
    chk("ovf_sticky", 16'(overflow), 16'h1);

    // Enable drop discards the held nibble
    cyc(0, 1, 1, 48, 48, 0); cyc(0, 1, 0, 0, 0, 0);
    chk("busy_held", 16'(busy), 16'h1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("busy_drop", 16'(busy), 16'h0);
    req_seen = 0;
    cyc(0, 1, 1, -48, -48, 0); req_seen += int'(wr_req);
    cyc(0, 1, 1, -48, -48, 0); req_seen += int'(wr_req);
    cyc(0, 1, 0, 0, 0, 0);     req_seen += int'(wr_req);
    chk("byte_00", 16'(wr_data), 16'h00);
    cyc(0, 1, 0, 0, 0, 0);     req_seen += int'(wr_req);
    chk("one_req", 16'(req_seen), 16'd1);

    // Back-to-back samples: one byte every two cycles
    req_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (k[0]) cyc(0, 1, 1, -10, -10, 0);
      else      cyc(0, 1, 1, 10, 10, 0);
      req_seen += int'(wr_req);
    end
    for (int k = 0; k < 2; k++) begin cyc(0, 1, 0, 0, 0, 0); req_seen += int'(wr_req); end
    chk("b2b_count", 16'(req_seen), 16'd4);
    chk("byte_F5", 16'(wr_data), 16'hF5);

`ifdef QAM16_SLICER_ERRCNT_EN
    repeat (3) cyc(1, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 1, 64, 0, 0);
    repeat (2) cyc(0, 1, 1, 10, 10, 0);
    repeat (2) cyc(0, 1, 0, 0, 0, 0);
    chk("err_3", err_count, 16'd3);
    cyc(0, 1, 1, 48, 48, 0);
    cyc(1, 1, 1, 48, 48, 0);
    chk("err_rst", err_count, 16'd0);
    chk("rst_req", 16'(wr_req), 16'h0);
    chk("rst_busy2", 16'(busy), 16'h0);
`endif

    // Randomized traffic with occasional reset, enable drops and full FIFO
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc(r < 2, r >= 8, $urandom_range(0, 3) != 0, pick(), pick(), $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
